exp_fp32_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 36 +++
 rtl/fp32_to_fixed.sv | 49 ++++
 rtl/exp_fp32_seq.sv | 216 +++++++++++++++++++++
 tb/tb_exp_fp32_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants, fixed-point constants and FSM state type
// for the transcendental units.
package fp_pkg;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE     = 32'h3F80_0000;

  // Largest positive input whose exponential is still finite (~88.72283).
  localparam logic [31:0] EXP_MAX_IN = 32'h42B1_7217;
  // Most negative input whose exponential is still a normal number (~-87.33655).
  localparam logic [31:0] EXP_MIN_IN = 32'hC2AE_AC50;

  // Constants in signed Q1.30.
  localparam int                 CONST_FRAC = 30;
  localparam logic signed [31:0] LOG2E_Q30  = 32'sh5C55_1D95;  // log2(e)
  localparam logic signed [31:0] LN2_Q30    = 32'sh2C5C_85FE;  // ln(2)

  // Width of the signed binary exponent k produced by range reduction.
  localparam int K_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_SERIES,
    S_PACK,
    S_DONE
  } exp_state_t;

  // 1/i rounded to nearest with 'frac' fraction bits.
  function automatic longint recip_q(input int i, input int frac);
    return ((longint'(1) <<< frac) + longint'(i / 2)) / longint'(i);
  endfunction

endpackage

// File: rtl/fp32_to_fixed.sv
// Combinational fp32 to signed Q8.FRAC_BITS conversion (truncating toward
// zero) with classification flags for the exponential unit.
module fp32_to_fixed
  import fp_pkg::*;
#(
  parameter  int FRAC_BITS = 24,
  localparam int FIX_W     = 8 + FRAC_BITS
)(
  input  logic [31:0]             a,
  output logic signed [FIX_W-1:0] fix,
  output logic                    isNaN,
  output logic                    isInf,
  output logic                    isZeroOrDenorm,
  output logic                    overflow,
  output logic                    underflow
);

  logic                    sgn;
  logic [7:0]              ex;
  logic [22:0]             man;
  logic signed [FIX_W-1:0] mag;
  int                      sh;

  assign sgn = a[31];
  assign ex  = a[30:23];
  assign man = a[22:0];

  // Align the 24-bit significand to the fixed-point grid, then apply the sign.
  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // branch, so no path can leave it unassigned and infer a latch.
    mag = '0;
    sh  = int'(ex) - 127 + FRAC_BITS - 23;
    if (sh >= 0) begin
      if (sh < FIX_W) mag = FIX_W'({1'b1, man}) << sh;
    end else if (sh > -24) begin
      mag = FIX_W'({1'b1, man} >> (-sh));
    end
    fix = sgn ? -mag : mag;
  end

  assign isNaN          = (ex == 8'hFF) && (man != '0);
  assign isInf          = (ex == 8'hFF) && (man == '0);
  assign isZeroOrDenorm = (ex == 8'h00);
  // For same-signed finite floats the magnitude bits order like integers.
  assign overflow       = !sgn && (ex != 8'hFF) && (a[30:0] > EXP_MAX_IN[30:0]);
  assign underflow      =  sgn && (ex != 8'hFF) && (a[30:0] > EXP_MIN_IN[30:0]);

endmodule

// File: rtl/exp_fp32_seq.sv
// Iterative fp32 natural exponential: range reduction x = k*ln2 + r, a Horner
// Taylor series for e^r over TERMS cycles, and repacking to fp32 with the
// exponent k. One general multiplier is shared by REDUCE and SERIES.
// FRAC_BITS is expected in 24..30.
module exp_fp32_seq
  import fp_pkg::*;
#(
  parameter int TERMS     = 10,
  parameter int FRAC_BITS = 24
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inputA,
  input  logic        inValid,
  output logic        inReady,
  output logic [31:0] out,
  output logic        outValid,
  input  logic        outReady
);

  localparam int FIX_W  = 8 + FRAC_BITS;
  localparam int IT_W   = $clog2(TERMS + 1);
  localparam int RW     = FIX_W + CONST_FRAC - FRAC_BITS + 8;
  localparam int Q30_SH = CONST_FRAC - FRAC_BITS;
  localparam int DROP   = FRAC_BITS - 23;
  localparam int E_W    = 12;

  localparam logic signed [FIX_W-1:0] ONE_FIX     = FIX_W'(longint'(1) <<< FRAC_BITS);
  localparam logic signed [FIX_W-1:0] TWO_FIX     = FIX_W'(longint'(2) <<< FRAC_BITS);
  localparam logic signed [FIX_W-1:0] LOG2E_FIX   = FIX_W'(LOG2E_Q30);
  localparam logic signed [RW-1:0]    LN2_R       = RW'(LN2_Q30);
  localparam logic [FRAC_BITS-1:0]    STICKY_MASK = FRAC_BITS'((longint'(1) <<< (DROP - 1)) - 1);
  localparam logic [IT_W-1:0]         TERMS_CNT   = IT_W'(TERMS);

  exp_state_t state, state_nx;

  // Operand conversion and classification
  logic signed [FIX_W-1:0] cvt_fix;
  logic cvt_nan, cvt_inf, cvt_zd, cvt_ovf, cvt_unf;
  logic        spec_hit;
  logic [31:0] spec_val;

  // Datapath registers
  logic signed [FIX_W-1:0] x_q, r_q, p_q;
  logic signed [K_W-1:0]   k_q;
  logic [IT_W-1:0]         iter_q;
  logic                    spec_q;
  logic [31:0]             spec_val_q;

  // Shared multiplier
  logic signed [FIX_W-1:0]   mul_a, mul_b;
  logic signed [2*FIX_W-1:0] mul_p;

  // Range reduction
  logic signed [K_W-1:0]   k_est, k_red;
  logic signed [RW-1:0]    x30, r30;
  logic signed [FIX_W-1:0] r_new;

  // Horner step
  logic signed [FIX_W-1:0]   recip_tbl [2**IT_W];
  logic signed [FIX_W-1:0]   pr_fix, p_new;
  logic signed [2*FIX_W-1:0] tr;

  // Packing
  logic                   p_two, guard, sticky, rnd_up, carry;
  logic [FRAC_BITS-1:0]   frac;
  logic [22:0]            mant_t, mant;
  logic [23:0]            mant_r;
  logic signed [E_W-1:0]  e_b;
  logic [31:0]            packed_res;

  fp32_to_fixed #(.FRAC_BITS(FRAC_BITS)) u_cvt (
    .a              (inputA),
    .fix            (cvt_fix),
    .isNaN          (cvt_nan),
    .isInf          (cvt_inf),
    .isZeroOrDenorm (cvt_zd),
    .overflow       (cvt_ovf),
    .underflow      (cvt_unf)
  );

  // Constant 1/i table indexed by the Horner iteration counter.
  for (genvar g = 0; g < 2**IT_W; g++) begin : g_recip
    if (g >= 1 && g <= TERMS) begin : g_used
      assign recip_tbl[g] = FIX_W'(recip_q(g, FRAC_BITS));
    end else begin : g_unused
      assign recip_tbl[g] = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx = state;
    inReady  = 1'b0;
    outValid = 1'b0;
    case (state)
      S_IDLE: begin
        inReady = 1'b1;
        if (inValid) state_nx = S_REDUCE;
      end
      S_REDUCE: state_nx = S_SERIES;
      S_SERIES: if (iter_q == IT_W'(1)) state_nx = S_PACK;
      S_PACK:   state_nx = S_DONE;
      S_DONE: begin
        outValid = 1'b1;
        if (outReady) state_nx = S_IDLE;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  // Special operands resolve to a fixed result at capture time.
  always_comb begin
    spec_hit = 1'b1;
    spec_val = FP32_ZERO;
    if      (cvt_nan) spec_val = FP32_QNAN;
    else if (cvt_inf) spec_val = inputA[31] ? FP32_ZERO : FP32_POS_INF;
    else if (cvt_zd)  spec_val = FP32_ONE;
    else if (cvt_ovf) spec_val = FP32_POS_INF;
    else if (cvt_unf) spec_val = FP32_ZERO;
    else              spec_hit = 1'b0;
  end

  // Multiplier operands: x*log2(e) during REDUCE, p*r during SERIES.
  always_comb begin
    mul_a = p_q;
    mul_b = r_q;
    if (state == S_REDUCE) begin
      mul_a = x_q;
      mul_b = LOG2E_FIX;
    end
  end

  assign mul_p = (2*FIX_W)'(mul_a) * (2*FIX_W)'(mul_b);

  // Range reduction: k = floor(x*log2e), r = x - k*ln2, one-step fix-up into [0, ln2).
  always_comb begin
    k_est = K_W'(mul_p >>> (FRAC_BITS + CONST_FRAC));
    x30   = RW'(x_q) <<< Q30_SH;
    r30   = x30 - RW'(k_est) * LN2_R;
    k_red = k_est;
    if (r30 < 0) begin
      r30   = r30 + LN2_R;
      k_red = k_est - K_W'(1);
    end else if (r30 >= LN2_R) begin
      r30   = r30 - LN2_R;
      k_red = k_est + K_W'(1);
    end
    r_new = FIX_W'(r30 >>> Q30_SH);
  end

  // Horner step: p = 1 + (p*r) * (1/i).
  always_comb begin
    pr_fix = FIX_W'(mul_p >>> FRAC_BITS);
    tr     = (2*FIX_W)'(pr_fix) * (2*FIX_W)'(recip_tbl[iter_q]);
    p_new  = ONE_FIX + FIX_W'(tr >>> FRAC_BITS);
  end

  // Pack p in [1,2) and k into fp32 with round-to-nearest-even.
  always_comb begin
    p_two  = (p_q >= TWO_FIX);
    frac   = FRAC_BITS'(p_q);
    mant_t = 23'(frac >> DROP);
    guard  = frac[DROP-1];
    sticky = |(frac & STICKY_MASK);
    rnd_up = guard & (sticky | mant_t[0]);
    mant_r = {1'b0, mant_t} + {23'b0, rnd_up};
    carry  = mant_r[23] | p_two;
    mant   = p_two ? '0 : mant_r[22:0];
    e_b    = E_W'(k_q) + E_W'(127) + {{(E_W-1){1'b0}}, carry};
    if (e_b >= E_W'(255))    packed_res = FP32_POS_INF;
    else if (e_b <= E_W'(0)) packed_res = FP32_ZERO;
    else                     packed_res = {1'b0, e_b[7:0], mant};
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk) begin
    // NOTE: these working registers are not reset; the FSM never reads them
    // before IDLE->REDUCE loads them, so reset only touches control and out.
    case (state)
      S_IDLE: begin
        if (inValid) begin
          x_q        <= cvt_fix;
          spec_q     <= spec_hit;
          spec_val_q <= spec_val;
        end
      end
      S_REDUCE: begin
        k_q    <= k_red;
        r_q    <= r_new;
        p_q    <= ONE_FIX;
        iter_q <= TERMS_CNT;
      end
      S_SERIES: begin
        p_q    <= p_new;
        iter_q <= iter_q - IT_W'(1);
      end
      default: ;
    endcase
  end

  // Result register, held stable through DONE.
  always_ff @(posedge clk) begin
    if (rst)                  out <= FP32_ZERO;
    else if (state == S_PACK) out <= spec_q ? spec_val_q : packed_res;
  end

endmodule

// File: tb/tb_exp_fp32_seq.sv
// Self-checking bench for exp_fp32_seq: directed values, special cases,
// handshake stalls, back-to-back streaming, mid-operation reset and a random
// sweep, with results matched through an in-order scoreboard.
module tb_exp_fp32_seq;

  localparam int    LATENCY = 12;
  localparam real   REL_TOL = 1.0e-5;
  localparam int    N_RAND  = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inputA;
  logic        inValid;
  logic        inReady;
  logic [31:0] out;
  logic        outValid;
  logic        outReady;

  int errors = 0;
  int checks = 0;
  int rand_pass = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] want;
    bit          approx;
    bit          is_rand;
    int          step;
  } sb_t;

  sb_t sb_q[$];
  sb_t item;

  logic [31:0] dir_in [15] = '{
    32'h0000_0000, 32'h3F80_0000, 32'hBF31_7218, 32'h4013_5D8E, 32'h42C8_0000,
    32'hC2C8_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h8000_0000,
    32'h0000_0001, 32'h42B1_999A, 32'hC2B0_0000, 32'h42B0_0000, 32'hC2AE_0000
  };
  logic [31:0] dir_want [15] = '{
    32'h3F80_0000, 32'h0,          32'h0,          32'h0,          32'h7F80_0000,
    32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000,
    32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0,          32'h0
  };
  bit dir_approx [15] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

  logic [31:0] b2b_in [4] = '{32'h3F00_0000, 32'hBF80_0000, 32'h40A0_0000, 32'h0000_0000};
  bit          b2b_approx [4] = '{1, 1, 1, 0};

  exp_fp32_seq dut (
    .clk      (clk),
    .rst      (rst),
    .inputA   (inputA),
    .inValid  (inValid),
    .inReady  (inReady),
    .out      (out),
    .outValid (outValid),
    .outReady (outReady)
  );

  always #5 clk = ~clk;

  function automatic real b2r(input logic [31:0] b);
    int  e;
    real m;
    real v;
    e = int'(b[30:23]);
    m = real'(b[22:0]);
    if (e == 0) v = m * (2.0 ** (-149.0));
    else        v = (1.0 + m / 8388608.0) * (2.0 ** real'(e - 127));
    return b[31] ? -v : v;
  endfunction

  // Scoreboard consumer: a result transfers on the edge after a negedge
  // where outValid and outReady are both high.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      checks++;
      assert (sb_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_result got=%h want=none", out);
      end
      if (sb_q.size() > 0) begin
        real want_r, got_r, diff;
        bit  ok;
        item = sb_q.pop_front();
        checks++;
        if (item.approx) begin
          want_r = $exp(b2r(item.a));
          got_r  = b2r(out);
          diff   = got_r - want_r;
          if (diff < 0.0) diff = -diff;
          ok = (out[31] == 1'b0) && (out[30:23] != 8'hFF) && (diff <= REL_TOL * want_r);
          assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL result step=%0d in=%h got=%h (%g) want=%g", item.step, item.a, out, got_r, want_r);
          end
          if (ok && item.is_rand) rand_pass++;
        end else begin
          assert (out === item.want) else begin
            errors++;
            $error("FAIL result step=%0d in=%h got=%h want=%h", item.step, item.a, out, item.want);
          end
        end
      end
    end
  end

  // Present an operand and wait (bounded) for it to be accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] want, input bit approx,
                      input bit is_rand, input bit push, input bit keep, input int step);
    int  g;
    sb_t s;
    g       = 0;
    inputA  = a;
    inValid = 1'b1;
    @(negedge clk);
    while (!inReady && g < 200) begin
      @(negedge clk);
      g++;
    end
    checks++;
    assert (inReady === 1'b1) else begin
      errors++;
      $error("FAIL accept_timeout step=%0d in=%h inReady=%b want=1", step, a, inReady);
    end
    if (push) begin
      s.a = a; s.want = want; s.approx = approx; s.is_rand = is_rand; s.step = step;
      sb_q.push_back(s);
    end
    @(posedge clk);
    #1;
    if (!keep) inValid = 1'b0;
  endtask

  // Count edges from acceptance to outValid; ends one edge later at +1.
  task automatic wait_result(input logic [31:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!outValid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checks++;
    assert (n === LATENCY) else begin
      errors++;
      $error("FAIL latency in=%h got=%0d want=%0d", a, n, LATENCY);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    checks++;
    assert (sb_q.size() === 0) else begin
      errors++;
      $error("FAIL drain_%s pending=%0d want=0", name, sb_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic [31:0] ra;
    int          ov_cnt;

    rst      = 1'b1;
    inValid  = 1'b0;
    inputA   = 32'h0;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    assert (inReady === 1'b1) else begin errors++; $error("FAIL reset_inReady got=%b want=1", inReady); end
    checks++;
    assert (outValid === 1'b0) else begin errors++; $error("FAIL reset_outValid got=%b want=0", outValid); end
    checks++;
    assert (out === 32'h0) else begin errors++; $error("FAIL reset_out got=%h want=00000000", out); end
    @(posedge clk);
    #1;

    // Directed values, special operands and range limits, one at a time.
    for (int i = 0; i < 15; i++) begin
      send(dir_in[i], dir_want[i], dir_approx[i], 1'b0, 1'b1, 1'b0, i);
      wait_result(dir_in[i]);
    end

    // Output stall: result must hold while outReady is low.
    outReady = 1'b0;
    send(32'h3F80_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 100);
    wait_result(32'h3F80_0000);
    held = out;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      assert (outValid === 1'b1) else begin errors++; $error("FAIL stall_outValid cyc=%0d got=%b want=1", c, outValid); end
      checks++;
      assert (out === held) else begin errors++; $error("FAIL stall_out cyc=%0d got=%h want=%h", c, out, held); end
      checks++;
      assert (inReady === 1'b0) else begin errors++; $error("FAIL stall_inReady cyc=%0d got=%b want=0", c, inReady); end
    end
    @(posedge clk);
    #1 outReady = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    assert (inReady === 1'b1) else begin errors++; $error("FAIL release_inReady got=%b want=1", inReady); end
    checks++;
    assert (outValid === 1'b0) else begin errors++; $error("FAIL release_outValid got=%b want=0", outValid); end

    // Back-to-back stream with inValid held high.
    for (int i = 0; i < 4; i++) begin
      send(b2b_in[i], 32'h3F80_0000, b2b_approx[i], 1'b0, 1'b1, 1'b1, 200 + i);
    end
    inValid = 1'b0;
    drain("b2b");

    // Reset during SERIES discards the operation.
    send(32'h4000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 300);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    assert (outValid === 1'b0) else begin errors++; $error("FAIL midrst_outValid got=%b want=0", outValid); end
    checks++;
    assert (inReady === 1'b1) else begin errors++; $error("FAIL midrst_inReady got=%b want=1", inReady); end
    checks++;
    assert (out === 32'h0) else begin errors++; $error("FAIL midrst_out got=%h want=00000000", out); end
    ov_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (outValid) ov_cnt++;
    end
    checks++;
    assert (ov_cnt === 0) else begin errors++; $error("FAIL midrst_stale got=%0d want=0", ov_cnt); end
    @(posedge clk);
    #1;

    // Random sweep over [-87, 88].
    for (int i = 0; i < N_RAND; i++) begin
      ra = 32'h3F80_0000;
      for (int t = 0; t < 100; t++) begin
        logic [31:0] cand;
        real         v;
        cand = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 133)), 23'($urandom)};
        v    = b2r(cand);
        if (v >= -87.0 && v <= 88.0) begin
          ra = cand;
          break;
        end
      end
      send(ra, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1000 + i);
    end
    inValid = 1'b0;
    drain("random");
    $display("random sweep: %0d of %0d within tolerance", rand_pass, N_RAND);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
